// File: rtl/bitserial_adder.sv
// Bit-serial adder/subtractor: adds BPC bits per clock, LSB first, through a
// registered carry. Operands are latched on the accept handshake, the result is
// held in DONE until the consumer takes it.
// Optional feature: define ADDER_SUB_EN to add the `sub` port (a - b - cin).
module bitserial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BPC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N        = (BPC == 0) ? 1 : WIDTH / BPC;
    localparam int unsigned CntW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] LastStep = CntW'(N - 1);

    // Reject configurations that cannot be processed in whole steps.
    generate
        if (WIDTH < 2 || BPC < 1 || BPC > WIDTH || (WIDTH % BPC) != 0) begin : g_bad_cfg
            $error("bitserial_adder: WIDTH must be >= 2 and a multiple of BPC");
        end
    endgenerate

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CntW-1:0]  cnt_q;

    logic             do_sub;
    logic [BPC:0]     step;
    logic             msb_cin;
    logic [WIDTH-1:0] sum_shift;

`ifdef ADDER_SUB_EN
    assign do_sub = sub;
`else
    assign do_sub = 1'b0;
`endif

    // One step of the serial datapath: add the low BPC bits of the shifting operands.
    always_comb begin
        step = (BPC+1)'(a_q[BPC-1:0]) + (BPC+1)'(b_q[BPC-1:0]) + (BPC+1)'(carry_q);
        // Carry into the top bit of this chunk; only meaningful on the last step (the MSB).
        msb_cin   = a_q[BPC-1] ^ b_q[BPC-1] ^ step[BPC-1];
        // New chunk enters at the top so the result is LSB-aligned after N steps.
        sum_shift = (sum >> BPC) | (WIDTH'(step[BPC-1:0]) << (WIDTH - BPC));
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + ~cin, so fold sub into the latched operands.
                        a_q      <= a;
                        b_q      <= do_sub ? ~b : b;
                        carry_q  <= cin ^ do_sub;
                        cnt_q    <= '0;
                        in_ready <= 1'b0;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    a_q     <= a_q >> BPC;
                    b_q     <= b_q >> BPC;
                    carry_q <= step[BPC];
                    sum     <= sum_shift;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LastStep) begin
                        cout      <= step[BPC];
                        ovf       <= step[BPC] ^ msb_cin;
                        out_valid <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitserial_adder.sv
// Bench for bitserial_adder: two instances (BPC=1 and BPC=4, WIDTH=8) checked every
// cycle against a transaction-level model, plus directed literal checks.
module tb_bitserial_adder;

    localparam int MIdle = 0;
    localparam int MRun  = 1;
    localparam int MDone = 2;
`ifdef ADDER_SUB_EN
    localparam bit HasSub = 1'b1;
`else
    localparam bit HasSub = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iv    [2];
    logic       ordy  [2];
    logic [7:0] a_i   [2];
    logic [7:0] b_i   [2];
    logic       cin_i [2];
    logic       s_i   [2];

    logic       d_in_ready  [2];
    logic       d_out_valid [2];
    logic [7:0] d_sum       [2];
    logic       d_cout      [2];
    logic       d_ovf       [2];

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model state per instance.
    int         m_phase [2];
    int         m_rem   [2];
    logic [9:0] m_pend  [2];
    logic [9:0] m_res   [2];
    int         nsteps  [2];

    always #5 clk = ~clk;

    bitserial_adder #(.WIDTH(8), .BPC(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(d_in_ready[0]),
        .a(a_i[0]), .b(b_i[0]), .cin(cin_i[0]),
`ifdef ADDER_SUB_EN
        .sub(s_i[0]),
`endif
        .out_valid(d_out_valid[0]), .out_ready(ordy[0]),
        .sum(d_sum[0]), .cout(d_cout[0]), .ovf(d_ovf[0])
    );

    bitserial_adder #(.WIDTH(8), .BPC(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(d_in_ready[1]),
        .a(a_i[1]), .b(b_i[1]), .cin(cin_i[1]),
`ifdef ADDER_SUB_EN
        .sub(s_i[1]),
`endif
        .out_valid(d_out_valid[1]), .out_ready(ordy[1]),
        .sum(d_sum[1]), .cout(d_cout[1]), .ovf(d_ovf[1])
    );

    // Whole-word reference: returns {ovf, cout, sum}.
    function automatic logic [9:0] ref_add(logic [7:0] a, logic [7:0] b, logic c, logic s);
        logic [7:0] be;
        logic       ce;
        logic [8:0] full;
        logic       v;
        be   = s ? ~b : b;
        ce   = s ? ~c : c;
        full = {1'b0, a} + {1'b0, be} + 9'(ce);
        v    = (a[7] == be[7]) && (full[7] != a[7]);
        return {v, full[8], full[7:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: accept in idle, N busy cycles, hold until taken.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_phase[k] <= MIdle;
                m_res[k]   <= '0;
            end else if (m_phase[k] == MIdle) begin
                if (iv[k]) begin
                    m_pend[k]  <= ref_add(a_i[k], b_i[k], cin_i[k], s_i[k] & HasSub);
                    m_rem[k]   <= nsteps[k];
                    m_phase[k] <= MRun;
                end
            end else if (m_phase[k] == MRun) begin
                if (m_rem[k] == 1) begin
                    m_phase[k] <= MDone;
                    m_res[k]   <= m_pend[k];
                end else begin
                    m_rem[k] <= m_rem[k] - 1;
                end
            end else if (ordy[k]) begin
                m_phase[k] <= MIdle;
            end
        end
    end

    // Per-cycle compare; results are not meaningful to the consumer during RUN.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("u%0d_in_ready", k), 32'(d_in_ready[k]), 32'(m_phase[k] == MIdle));
                check($sformatf("u%0d_out_valid", k), 32'(d_out_valid[k]),
                      32'(m_phase[k] == MDone));
                if (m_phase[k] != MRun) begin
                    check($sformatf("u%0d_sum", k), 32'(d_sum[k]), 32'(m_res[k][7:0]));
                    check($sformatf("u%0d_cout", k), 32'(d_cout[k]), 32'(m_res[k][8]));
                    check($sformatf("u%0d_ovf", k), 32'(d_ovf[k]), 32'(m_res[k][9]));
                end
            end
        end
    end

    // Accept one operation on instance k and check latency and result literals.
    task automatic directed(input int k, input string tag, input logic [7:0] av,
                            input logic [7:0] bv, input logic cv, input logic sv,
                            input int hold, input int exp_lat, input logic [7:0] es,
                            input logic ec, input logic eo);
        int n;
        @(negedge clk);
        iv[k] = 1'b1; a_i[k] = av; b_i[k] = bv; cin_i[k] = cv; s_i[k] = sv; ordy[k] = 1'b0;
        n = 0;
        while (!d_in_ready[k] && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        // Scramble inputs after the accept edge: the operands must have been latched.
        iv[k] = 1'b0; a_i[k] = 8'($urandom); b_i[k] = 8'($urandom); cin_i[k] = 1'($urandom);
        s_i[k] = 1'($urandom);
        n = 0;
        while (!d_out_valid[k] && n < 50) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_sum"}, 32'(d_sum[k]), 32'(es));
        check({tag, "_cout"}, 32'(d_cout[k]), 32'(ec));
        check({tag, "_ovf"}, 32'(d_ovf[k]), 32'(eo));
        for (int i = 0; i < hold; i++) begin
            iv[k] = 1'($urandom_range(0, 1)); a_i[k] = 8'($urandom); b_i[k] = 8'($urandom);
            @(negedge clk);
            check({tag, "_hold_in_ready"}, 32'(d_in_ready[k]), 32'd0);
            check({tag, "_hold_sum"}, 32'(d_sum[k]), 32'(es));
        end
        iv[k] = 1'b0; ordy[k] = 1'b1;
        @(negedge clk);
        ordy[k] = 1'b0;
        check({tag, "_idle_after_take"}, 32'(d_in_ready[k]), 32'd1);
    endtask

    initial begin
        nsteps[0] = 8;
        nsteps[1] = 2;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b0; a_i[k] = '0; b_i[k] = '0; cin_i[k] = 1'b0;
            s_i[k] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_out_valid", 32'(d_out_valid[0]), 32'd0);
        check("reset_sum", 32'(d_sum[0]), 32'd0);

        directed(0, "ff_plus_01", 8'hFF, 8'h01, 1'b0, 1'b0, 0, 8, 8'h00, 1'b1, 1'b0);
        directed(0, "7f_plus_01_hold", 8'h7F, 8'h01, 1'b0, 1'b0, 5, 8, 8'h80, 1'b0, 1'b1);

        // Reset in the third RUN cycle.
        @(negedge clk);
        iv[0] = 1'b1; a_i[0] = 8'h12; b_i[0] = 8'h34; cin_i[0] = 1'b0;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_run_out_valid", 32'(d_out_valid[0]), 32'd0);
        check("rst_run_sum", 32'(d_sum[0]), 32'd0);
        check("rst_run_in_ready", 32'(d_in_ready[0]), 32'd1);
        directed(0, "after_rst_3c_5a", 8'h3C, 8'h5A, 1'b1, 1'b0, 0, 8, 8'h97, 1'b0, 1'b1);

        directed(1, "bpc4_3c_5a", 8'h3C, 8'h5A, 1'b1, 1'b0, 2, 2, 8'h97, 1'b0, 1'b1);
`ifdef ADDER_SUB_EN
        directed(0, "sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 0, 8, 8'hFE, 1'b0, 1'b0);
`endif

        // Randomized traffic on both instances with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 199) == 0);
            for (int k = 0; k < 2; k++) begin
                iv[k]    = ($urandom_range(0, 3) != 0);
                ordy[k]  = 1'($urandom_range(0, 1));
                a_i[k]   = 8'($urandom);
                b_i[k]   = 8'($urandom);
                cin_i[k] = 1'($urandom);
                s_i[k]   = 1'($urandom);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0;
            ordy[k] = 1'b1;
        end
        repeat (20) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
